// File: rtl/clock_pattern_gen_pkg.sv
// ============================================================================
// clock_pattern_gen_pkg : shared state type and training-pattern defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package clock_pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TOGGLE = 2'd1,
        LOW    = 2'd2,
        DONE   = 2'd3
    } clk_pat_state_e;

    // Consumed by both the generator and the far-end detector
    localparam int UCIE_TOGGLE_CYC = 16;
    localparam int UCIE_LOW_CYC    = 8;
    localparam int UCIE_ITERATIONS = 128;

    function automatic int cp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_pattern_gen_if.sv
// ============================================================================
// clock_pattern_gen_if : training handshake and clock-gate control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface clock_pattern_gen_if;

    logic i_start_clk_pattern;
    logic i_free_run;
    logic o_clk_en;
    logic o_busy;
    logic o_done;

    modport master (
        output i_start_clk_pattern,
        output i_free_run,
        input  o_clk_en,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start_clk_pattern,
        input  i_free_run,
        output o_clk_en,
        output o_busy,
        output o_done
    );

endinterface

`default_nettype wire

// File: rtl/clock_pattern_gen_bit_sync.sv
// ============================================================================
// bit_sync : generic multi-flop level synchronizer, async active-low reset
// Rev 1.0
// ============================================================================
`default_nettype none

module bit_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic d_i,
    output logic      q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/clock_pattern_gen.sv
// ============================================================================
// clock_pattern_gen : forwarded-clock training pattern generator (TX side)
// Rev 1.0
// ============================================================================
`default_nettype none

module clock_pattern_gen
    import clock_pattern_gen_pkg::*;
#(
    parameter int TOGGLE_CYC = UCIE_TOGGLE_CYC,
    parameter int LOW_CYC    = UCIE_LOW_CYC,
    parameter int ITERATIONS = UCIE_ITERATIONS
) (
    input  wire logic            i_RCLK,
    input  wire logic            i_rst_n,
    clock_pattern_gen_if.slave   pat_if
);

    localparam int PHASE_MAX = cp_max(TOGGLE_CYC, LOW_CYC);
    localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int ITER_W    = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [PHASE_W-1:0] TOG_LAST  = PHASE_W'(TOGGLE_CYC - 1);
    localparam logic [PHASE_W-1:0] LOW_LAST  = PHASE_W'(LOW_CYC - 1);
    localparam logic [ITER_W-1:0]  ITER_LAST = ITER_W'(ITERATIONS - 1);

    logic                start_s;
    clk_pat_state_e      state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [ITER_W-1:0]   iter_q,  iter_d;
    logic                clk_en_q, clk_en_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    bit_sync #(
        .STAGES (2)
    ) u_start_sync (
        .clk_i  (i_RCLK),
        .rst_ni (i_rst_n),
        .d_i    (pat_if.i_start_clk_pattern),
        .q_o    (start_s)
    );

    always_ff @(posedge i_RCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            iter_q   <= '0;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            iter_q   <= iter_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Losing the request in TOGGLE/LOW aborts ahead of any phase transition
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = TOGGLE;
                    phase_d = '0;
                    iter_d  = '0;
                end
            end
            TOGGLE: begin
                if (!start_s) begin
                    state_d = IDLE;
                    phase_d = '0;
                    iter_d  = '0;
                end else if (phase_q == TOG_LAST) begin
                    state_d = LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            LOW: begin
                if (!start_s) begin
                    state_d = IDLE;
                    phase_d = '0;
                    iter_d  = '0;
                end else if (phase_q == LOW_LAST) begin
                    phase_d = '0;
                    if (iter_q == ITER_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = TOGGLE;
                        iter_d  = iter_q + ITER_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            DONE: begin
                if (!start_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops glitch-free
    always_comb begin
        clk_en_d = (state_d == TOGGLE) || ((state_d == IDLE) && pat_if.i_free_run);
        busy_d   = (state_d == TOGGLE) || (state_d == LOW);
        done_d   = (state_d == DONE);
    end

    assign pat_if.o_clk_en = clk_en_q;
    assign pat_if.o_busy   = busy_q;
    assign pat_if.o_done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_pattern_gen.sv
// ============================================================================
// tb_clock_pattern_gen : directed bench with cycle-level pattern model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clock_pattern_gen;

    localparam int TG0 = 16, LW0 = 8, IT0 = 128;
    localparam int TG1 = 4,  LW1 = 2, IT1 = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    clock_pattern_gen_if bus0 ();
    clock_pattern_gen_if bus1 ();

    clock_pattern_gen dut0 (
        .i_RCLK  (clk),
        .i_rst_n (rst_n),
        .pat_if  (bus0)
    );

    clock_pattern_gen #(
        .TOGGLE_CYC (TG1),
        .LOW_CYC    (LW1),
        .ITERATIONS (IT1)
    ) dut1 (
        .i_RCLK  (clk),
        .i_rst_n (rst_n),
        .pat_if  (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a pattern is "elapsed cycles t since start"; enable is high in the
    // first TG cycles of every TG+LW period, and it ends after IT periods.
    int   m_mode [2] = '{0, 0};   // 0 idle, 1 running, 2 done
    int   m_t    [2] = '{0, 0};
    logic m_s1   [2] = '{1'b0, 1'b0};
    logic m_s2   [2] = '{1'b0, 1'b0};
    logic e_en   [2] = '{1'b0, 1'b0};
    logic e_busy [2] = '{1'b0, 1'b0};
    logic e_done [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_t[i] = 0; m_s1[i] = 1'b0; m_s2[i] = 1'b0;
                e_en[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic ss, rq, fr;
                int   per, plen, tg;
                per  = (i == 0) ? (TG0 + LW0) : (TG1 + LW1);
                plen = (i == 0) ? IT0 * per : IT1 * per;
                tg   = (i == 0) ? TG0 : TG1;
                rq   = (i == 0) ? bus0.i_start_clk_pattern : bus1.i_start_clk_pattern;
                fr   = (i == 0) ? bus0.i_free_run : bus1.i_free_run;
                ss   = m_s2[i];
                case (m_mode[i])
                    0: if (ss) begin m_mode[i] = 1; m_t[i] = 0; end
                    1: begin
                        if (!ss) m_mode[i] = 0;
                        else begin
                            m_t[i]++;
                            if (m_t[i] == plen) m_mode[i] = 2;
                        end
                    end
                    default: if (!ss) m_mode[i] = 0;
                endcase
                m_s2[i]   = m_s1[i];
                m_s1[i]   = rq;
                e_busy[i] = (m_mode[i] == 1);
                e_done[i] = (m_mode[i] == 2);
                e_en[i]   = ((m_mode[i] == 1) && ((m_t[i] % per) < tg)) ||
                            ((m_mode[i] == 0) && fr);
            end
        end
    end

    always @(negedge clk) begin
        chk("m_clk_en0", int'(bus0.o_clk_en), int'(e_en[0]));
        chk("m_busy0",   int'(bus0.o_busy),   int'(e_busy[0]));
        chk("m_done0",   int'(bus0.o_done),   int'(e_done[0]));
        chk("m_clk_en1", int'(bus1.o_clk_en), int'(e_en[1]));
        chk("m_busy1",   int'(bus1.o_busy),   int'(e_busy[1]));
        chk("m_done1",   int'(bus1.o_done),   int'(e_done[1]));
    end

    task automatic edge_();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_busy0(input string nm);
        int n;
        n = 0;
        while (!bus0.o_busy && n < 10) begin edge_(); n++; end
        chk(nm, int'(bus0.o_busy), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, ones, rises, run, n;
        logic prev;
        bus0.i_start_clk_pattern = 1'b0; bus0.i_free_run = 1'b0;
        bus1.i_start_clk_pattern = 1'b0; bus1.i_free_run = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) edge_();
        chk("rst_clk_en", int'(bus0.o_clk_en), 0);
        chk("rst_busy",   int'(bus0.o_busy),   0);
        chk("rst_done",   int'(bus0.o_done),   0);
        rst_n = 1'b1;
        edge_();

        // Nominal run with start latency pinned
        bus0.i_start_clk_pattern = 1'b1;
        edge_(); chk("lat_k_busy",  int'(bus0.o_busy), 0);
        edge_(); chk("lat_k1_busy", int'(bus0.o_busy), 0);
        edge_(); chk("lat_k2_busy", int'(bus0.o_busy), 1);
        chk("lat_k2_en", int'(bus0.o_clk_en), 1);
        cnt = 1; ones = 1; rises = 1; prev = 1'b1; n = 0;
        while (bus0.o_busy && n < 4000) begin
            edge_(); n++;
            if (bus0.o_busy) begin
                cnt++;
                if (bus0.o_clk_en) ones++;
                if (bus0.o_clk_en && !prev) rises++;
                prev = bus0.o_clk_en;
            end
        end
        chk("busy_len",   cnt,   3072);
        chk("en_ones",    ones,  2048);
        chk("en_bursts",  rises, 128);
        chk("done_at_busy_fall", int'(bus0.o_done), 1);
        bus0.i_start_clk_pattern = 1'b0;
        edge_(); chk("done_rel_k",  int'(bus0.o_done), 1);
        edge_(); chk("done_rel_k1", int'(bus0.o_done), 1);
        edge_(); chk("done_rel_k2", int'(bus0.o_done), 0);
        edge_();

        // Abort at iteration 5, TOGGLE phase 10
        bus0.i_start_clk_pattern = 1'b1;
        wait_busy0("abort_start");
        repeat (130) edge_();
        chk("abort_pre_en", int'(bus0.o_clk_en), 1);
        bus0.i_start_clk_pattern = 1'b0;
        edge_(); chk("abort_k_busy",  int'(bus0.o_busy), 1);
        edge_(); chk("abort_k1_busy", int'(bus0.o_busy), 1);
        edge_(); chk("abort_k2_busy", int'(bus0.o_busy), 0);
        chk("abort_k2_en", int'(bus0.o_clk_en), 0);
        repeat (8) edge_();
        chk("abort_no_done", int'(bus0.o_done), 0);
        bus0.i_start_clk_pattern = 1'b1;
        wait_busy0("restart");
        run = 1; n = 0;
        while (n < 30) begin
            edge_(); n++;
            if (bus0.o_clk_en) run++; else break;
        end
        chk("restart_burst", run, 16);
        bus0.i_start_clk_pattern = 1'b0;
        repeat (4) edge_();

        // Free run in IDLE
        bus0.i_free_run = 1'b1;
        edge_(); chk("fr_idle_en", int'(bus0.o_clk_en), 1);
        bus0.i_start_clk_pattern = 1'b1;
        wait_busy0("fr_start");
        repeat (16) edge_();
        chk("fr_low_en", int'(bus0.o_clk_en), 0);
        n = 0;
        while (!bus0.o_done && n < 3200) begin edge_(); n++; end
        chk("fr_done", int'(bus0.o_done), 1);
        chk("fr_done_en", int'(bus0.o_clk_en), 0);
        bus0.i_start_clk_pattern = 1'b0;
        edge_(); edge_();
        chk("fr_rel_k1_en", int'(bus0.o_clk_en), 0);
        edge_();
        chk("fr_rel_k2_en", int'(bus0.o_clk_en), 1);
        bus0.i_free_run = 1'b0;
        edge_();

        // Reset during the third LOW phase
        bus0.i_start_clk_pattern = 1'b1;
        wait_busy0("rst_mid_start");
        repeat (66) edge_();
        chk("low3_en",   int'(bus0.o_clk_en), 0);
        chk("low3_busy", int'(bus0.o_busy),   1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_en",   int'(bus0.o_clk_en), 0);
        chk("rst_mid_busy", int'(bus0.o_busy),   0);
        chk("rst_mid_done", int'(bus0.o_done),   0);
        edge_();
        rst_n = 1'b1;
        edge_(); chk("rel_k_busy",  int'(bus0.o_busy), 0);
        edge_(); chk("rel_k1_en",   int'(bus0.o_clk_en), 0);
        edge_(); chk("rel_k2_busy", int'(bus0.o_busy), 1);
        run = 1; n = 0;
        while (n < 30) begin
            edge_(); n++;
            if (bus0.o_clk_en) run++; else break;
        end
        chk("rel_burst", run, 16);
        bus0.i_start_clk_pattern = 1'b0;
        repeat (4) edge_();

        // Small parameter set: 4 on, 2 off, 1 iteration
        bus1.i_start_clk_pattern = 1'b1;
        n = 0;
        while (!bus1.o_busy && n < 10) begin edge_(); n++; end
        cnt = 0; n = 0;
        while (bus1.o_busy && n < 20) begin cnt++; edge_(); n++; end
        chk("sweep_busy_len", cnt, 6);
        chk("sweep_done", int'(bus1.o_done), 1);
        bus1.i_start_clk_pattern = 1'b0;
        repeat (3) edge_();
        chk("sweep_done_rel", int'(bus1.o_done), 0);
        edge_();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
